i2c_slave_max30100_emu: RTL and testbench
=========================================

Name: i2c_slave_max30100_emu

Overview:
Synthesizable I2C target that emulates a MAX30100 at slave address 0x57. Bench and hardware-in-the-loop use: it sits on the sda_max/scl_max bus opposite the sensor-side I2C master. It oversamples SCL/SDA with clk_1MHz and serves a small register map. FIFO_DATA reads are fed from an internal 16-bit sample buffer loaded by a pattern source through sample_valid/sample_ready.

Parameters:
SLAVE_ADDR, 7'h57, 7-bit address this target ACKs.
BUF_DEPTH, 8, sample buffer depth in 16-bit words (power of 2).
PART_ID, 8'h11, value returned at register 0xFF.

Ports:
clk_1MHz  in  1  system clock; bus sampled on every edge.
rst_n  in  1  asynchronous, active-low reset.
scl_in  in  1  bus SCL, asynchronous to clk_1MHz.
sda  inout  1  bus SDA, open-drain: driven 0 or released (z), never driven 1.
sample_data  in  16  next emulated sample word.
sample_valid  in  1  push request for sample_data.
sample_ready  out  1  high when buffer not full.
mode_cfg  out  8  register 0x06 contents.
spo2_cfg  out  8  register 0x07 contents.
buf_count  out  $clog2(BUF_DEPTH)+1  words held.
busy  out  1  high from addressed START (ACKed) to STOP/NACK-abort.

Behaviour:
- Reset is asynchronous, active-low, on clock clk_1MHz. All outputs are 0 after reset; sample_ready=1; sda released; FSM=IDLE; buffer empty; ovf_cnt=0; reg_ptr=0.
- Bus input: 2-FF synchronizer on scl_in and on sda, then 1-cycle edge detect. SCL is limited to 100 kHz, with high and low phases ≥4 us. SDA changes ≥1 clk after SCL fall.
- START/Sr: SDA falls while SCL high. Goes to ADDR from any state and clears the bit counter.
- STOP: SDA rises while SCL high. Goes to IDLE from any state, releases sda and clears busy.
- Bits are shifted MSB-first on SCL rising edge.
- The target changes SDA 1 clk after a detected SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT.
  - ADDR: after 8 bits, address==SLAVE_ADDR → ADDR_ACK and drive 0 during the 9th clock. Mismatch → WAIT with no drive.
  - ADDR_ACK, R/W=0 → REG.
  - ADDR_ACK, R/W=1 → load the byte at reg_ptr into tx shift register, then RDATA.
  - REG: 8 bits → reg_ptr, then ACK → WDATA.
  - WDATA: 8 bits → write reg_ptr if RW, then ACK.
  - RDATA: drive tx bits, release for the 9th bit, go to MACK.
  - MACK: master ACK (SDA=0) → load next byte, RDATA. Master NACK → WAIT.
  - WAIT: ignore bus until START/STOP.
- reg_ptr increments by 1 (8-bit wrap 0xFF→0x00) after each data byte, except it holds at 0x09.
- Register map:
  - 0x00 INT_STATUS RO = {2'b00, !empty, 5'b0}.
  - 0x02 FIFO_WR_PTR RO = buffer write pointer.
  - 0x04 OVF_COUNTER RO = ovf_cnt, saturating at 15.
  - 0x06 MODE RW.
  - 0x07 SPO2 RW.
  - 0x09 FIFO_DATA RO.
  - 0xFF PART_ID RO.
  - Other addresses read 0x00.
  - Writes to RO or unmapped registers are ACKed and ignored.
- FIFO_DATA reads: alternates MSB then LSB of the head word, using a byte_sel flag that resets to MSB on every START.
  - The word is popped when its LSB is loaded into the tx register.
  - Empty buffer: return 0x00 for both bytes, no pop, no underflow of pointers.
- Buffer push: sample_valid && sample_ready writes the tail.
  - Push and pop in the same cycle both take effect; count is unchanged.
  - Push while full is dropped and ovf_cnt increments, saturating at 15.
  - ovf_cnt clears when register 0x04 is read.
- busy rises on ADDR_ACK and falls on STOP or on entering WAIT.
- Reset mid-transfer releases sda immediately; asynchronous.

Test Plan:
- Write 0x57/W, reg 0x06, data 0x03, STOP → ACK on all 3 bytes; mode_cfg=0x03; busy low after STOP.
- Write 0x57/W reg 0xFF, Sr, 0x57/R, 1 byte NACK → returns 0x11; sda released after NACK.
- Push 0xA1B2, 0xC3D4; read 0x09 with 4 bytes (ACK,ACK,ACK,NACK) → 0xA1,0xB2,0xC3,0xD4; buf_count 2→0.
- Address 0x3C → no ACK (SDA high on 9th clock); later bytes ignored; busy stays 0; registers unchanged.
- Push 9 words at BUF_DEPTH=8 → sample_ready=0 after 8; read 0x04 → 0x01; read again → 0x00.
- Empty buffer, read 0x09 with 2 bytes → 0x00,0x00; buf_count stays 0. Reset asserted mid-read → sda z, FSM IDLE, outputs reset.

Source files
------------

// File: rtl/i2c_slave_max30100_emu.sv
// I2C target that emulates a MAX30100 pulse-oximeter at a fixed 7-bit address.
// The bus is oversampled with clk_1MHz. FIFO_DATA reads are served from a small
// 16-bit sample buffer that a pattern source fills through sample_valid/ready.
module i2c_slave_max30100_emu #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h57,
    parameter int unsigned BUF_DEPTH  = 8,
    parameter logic [7:0]  PART_ID    = 8'h11
) (
    input  logic                       clk_1MHz,
    input  logic                       rst_n,
    input  logic                       scl_in,
    inout  wire                        sda,
    input  logic [15:0]                sample_data,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic [7:0]                 mode_cfg,
    output logic [7:0]                 spo2_cfg,
    output logic [$clog2(BUF_DEPTH):0] buf_count,
    output logic                       busy
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StAddr     = 4'd1;
    localparam logic [3:0] StAddrAck  = 4'd2;
    localparam logic [3:0] StReg      = 4'd3;
    localparam logic [3:0] StRegAck   = 4'd4;
    localparam logic [3:0] StWdata    = 4'd5;
    localparam logic [3:0] StWdataAck = 4'd6;
    localparam logic [3:0] StRdata    = 4'd7;
    localparam logic [3:0] StMack     = 4'd8;
    localparam logic [3:0] StWait     = 4'd9;

    localparam logic [7:0] RegIntStatus = 8'h00;
    localparam logic [7:0] RegWrPtr     = 8'h02;
    localparam logic [7:0] RegOvf       = 8'h04;
    localparam logic [7:0] RegMode      = 8'h06;
    localparam logic [7:0] RegSpo2      = 8'h07;
    localparam logic [7:0] RegFifo      = 8'h09;
    localparam logic [7:0] RegPartId    = 8'hFF;

    // Bus synchronizers and edge detection
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    // Protocol state
    logic [3:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] rx_next;
    logic [6:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] reg_ptr_q, reg_ptr_d;
    logic [7:0] ptr_adv;
    logic       byte_sel_q, byte_sel_d;
    logic [7:0] mode_q, mode_d;
    logic [7:0] spo2_q, spo2_d;
    logic       load;
    logic [7:0] rd_byte;

    // Sample buffer
    logic [15:0]   mem_q [BUF_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [3:0]    ovf_q, ovf_d;
    logic [15:0]   head;
    logic          full, empty, push, drop, pop, ovf_clr;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Open-drain: only ever pull low or release.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    assign rx_next = {rx_q, sda_s};
    // FIFO_DATA is a streaming port, so the pointer parks there for burst reads.
    assign ptr_adv = (reg_ptr_q == RegFifo) ? reg_ptr_q : reg_ptr_q + 8'd1;

    assign full  = (count_q == CW'(BUF_DEPTH));
    assign empty = (count_q == '0);
    assign push  = sample_valid & ~full;
    assign drop  = sample_valid & full;
    assign head  = mem_q[rd_ptr_q];

    assign sample_ready = ~full;
    assign mode_cfg     = mode_q;
    assign spo2_cfg     = spo2_q;
    assign buf_count    = count_q;
    assign busy         = busy_q;

    // Two-flop synchronizers plus a delayed copy; reset to the idle-high bus level.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    // Register-map read mux feeding the transmit shifter.
    always_comb begin
        rd_byte = 8'h00;
        case (reg_ptr_q)
            RegIntStatus: rd_byte = {2'b00, ~empty, 5'b00000};
            RegWrPtr:     rd_byte = 8'(wr_ptr_q);
            RegOvf:       rd_byte = {4'b0000, ovf_q};
            RegMode:      rd_byte = mode_q;
            RegSpo2:      rd_byte = spo2_q;
            RegFifo: begin
                if (!empty) rd_byte = byte_sel_q ? head[7:0] : head[15:8];
            end
            RegPartId:    rd_byte = PART_ID;
            default:      rd_byte = 8'h00;
        endcase
    end

    // Protocol FSM next-state; START/STOP override whatever the state decided.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        reg_ptr_d  = reg_ptr_q;
        byte_sel_d = byte_sel_q;
        mode_d     = mode_q;
        spo2_d     = spo2_q;
        load       = 1'b0;
        pop        = 1'b0;
        ovf_clr    = 1'b0;

        case (state_q)
            StAddr: begin
                if (scl_rise) begin
                    rx_d      = rx_next[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rw_d = rx_next[0];
                        if (rx_next[7:1] == SLAVE_ADDR) begin
                            state_d = StAddrAck;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = StWait;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            // In ACK states the first fall starts driving, the next fall ends the 9th clock.
            StAddrAck: begin
                if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (rw_q) begin
                        load      = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = StRdata;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StReg;
                    end
                end
            end
            StReg: begin
                if (scl_rise) begin
                    rx_d      = rx_next[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        reg_ptr_d = rx_next;
                        state_d   = StRegAck;
                    end
                end
            end
            StRegAck, StWdataAck: begin
                if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StWdata;
                    end
                end
            end
            StWdata: begin
                if (scl_rise) begin
                    rx_d      = rx_next[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (reg_ptr_q == RegMode) mode_d = rx_next;
                        if (reg_ptr_q == RegSpo2) spo2_d = rx_next;
                        reg_ptr_d = ptr_adv;
                        state_d   = StWdataAck;
                    end
                end
            end
            StRdata: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = StMack;
                    end else begin
                        tx_d     = {tx_q[5:0], 1'b0};
                        sda_oe_d = ~tx_q[6];
                    end
                end
            end
            // bit_cnt 9 marks a master ACK seen on this clock's rising edge.
            StMack: begin
                if (scl_rise) begin
                    if (sda_s) begin
                        state_d = StWait;
                        busy_d  = 1'b0;
                    end else begin
                        bit_cnt_d = 4'd9;
                    end
                end else if (scl_fall && bit_cnt_q == 4'd9) begin
                    load      = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = StRdata;
                end
            end
            StIdle, StWait: begin
            end
            default: state_d = StIdle;
        endcase

        // Loading a byte is what counts as reading it: pointer, pop and clear-on-read happen here.
        if (load) begin
            tx_d      = rd_byte[6:0];
            sda_oe_d  = ~rd_byte[7];
            reg_ptr_d = ptr_adv;
            if (reg_ptr_q == RegFifo && !empty) begin
                byte_sel_d = ~byte_sel_q;
                pop        = byte_sel_q;
            end
            if (reg_ptr_q == RegOvf) ovf_clr = 1'b1;
        end

        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d    = StAddr;
            bit_cnt_d  = 4'd0;
            sda_oe_d   = 1'b0;
            byte_sel_d = 1'b0;
        end
    end

    // Protocol FSM and register state.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            rx_q       <= 7'd0;
            tx_q       <= 7'd0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            reg_ptr_q  <= 8'h00;
            byte_sel_q <= 1'b0;
            mode_q     <= 8'h00;
            spo2_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            reg_ptr_q  <= reg_ptr_d;
            byte_sel_q <= byte_sel_d;
            mode_q     <= mode_d;
            spo2_q     <= spo2_d;
        end
    end

    // Overflow counter saturates at 15; a read of it wins over a same-cycle drop.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 4'd0;
        end else if (drop && ovf_q != 4'd15) begin
            ovf_d = ovf_q + 4'd1;
        end
    end

    // Buffer pointers, occupancy and overflow count.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 4'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
            ovf_q   <= ovf_d;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk_1MHz) begin
        if (push) mem_q[wr_ptr_q] <= sample_data;
    end

endmodule

// File: tb/tb_i2c_slave_max30100_emu.sv
// Directed bench for i2c_slave_max30100_emu: a bit-banged I2C master with a
// pull-up on SDA, hand-computed expected values and one checking task.
module tb_i2c_slave_max30100_emu;

    logic        clk_1MHz = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        m_sda_oe;
    wire         sda;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  mode_cfg;
    logic [7:0]  spo2_cfg;
    logic [3:0]  buf_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #500 clk_1MHz = ~clk_1MHz;

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup pu_sda (sda);

    i2c_slave_max30100_emu dut (
        .clk_1MHz     (clk_1MHz),
        .rst_n        (rst_n),
        .scl_in       (scl),
        .sda          (sda),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mode_cfg     (mode_cfg),
        .spo2_cfg     (spo2_cfg),
        .buf_count    (buf_count),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_1MHz);
    endtask

    task automatic i2c_start();
        m_sda_oe = 1'b0;
        clks(3);
        scl = 1'b1;
        clks(5);
        m_sda_oe = 1'b1;
        clks(5);
        scl = 1'b0;
        clks(2);
    endtask

    task automatic i2c_stop();
        m_sda_oe = 1'b1;
        clks(3);
        scl = 1'b1;
        clks(5);
        m_sda_oe = 1'b0;
        clks(5);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            clks(2);
            m_sda_oe = ~b[i];
            clks(3);
            scl = 1'b1;
            clks(5);
            scl = 1'b0;
        end
        clks(2);
        m_sda_oe = 1'b0;
        clks(3);
        scl = 1'b1;
        clks(3);
        acked = (sda == 1'b0);
        clks(2);
        scl = 1'b0;
        clks(4);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda_oe = 1'b0;
            clks(5);
            scl = 1'b1;
            clks(3);
            b[i] = sda;
            clks(2);
            scl = 1'b0;
        end
        clks(2);
        m_sda_oe = ack;
        clks(3);
        scl = 1'b1;
        clks(5);
        scl = 1'b0;
        clks(2);
        m_sda_oe = 1'b0;
    endtask

    // Set pointer, repeated START, read one byte with NACK, STOP.
    task automatic read_reg(input logic [7:0] addr, output logic [7:0] data);
        logic a;
        i2c_start();
        send_byte(8'hAE, a);
        send_byte(addr, a);
        i2c_start();
        send_byte(8'hAF, a);
        check("rd_addr_ack", 32'(a), 1);
        recv_byte(1'b0, data);
        i2c_stop();
    endtask

    task automatic push(input logic [15:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        clks(1);
        sample_valid = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;

        rst_n        = 1'b0;
        scl          = 1'b1;
        m_sda_oe     = 1'b0;
        sample_data  = 16'h0000;
        sample_valid = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(3);

        // Reset state
        check("rst_mode", 32'(mode_cfg), 0);
        check("rst_spo2", 32'(spo2_cfg), 0);
        check("rst_count", 32'(buf_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(sample_ready), 1);
        check("rst_sda", 32'(sda), 1);

        // Single write to MODE
        i2c_start();
        send_byte(8'hAE, ack);
        check("t1_addr_ack", 32'(ack), 1);
        send_byte(8'h06, ack);
        check("t1_reg_ack", 32'(ack), 1);
        check("t1_busy", 32'(busy), 1);
        send_byte(8'h03, ack);
        check("t1_data_ack", 32'(ack), 1);
        i2c_stop();
        check("t1_mode", 32'(mode_cfg), 32'h03);
        check("t1_busy_stop", 32'(busy), 0);

        // Burst write MODE then SPO2 via pointer increment
        i2c_start();
        send_byte(8'hAE, ack);
        send_byte(8'h06, ack);
        send_byte(8'h05, ack);
        send_byte(8'h47, ack);
        check("t1b_ack", 32'(ack), 1);
        i2c_stop();
        check("t1b_mode", 32'(mode_cfg), 32'h05);
        check("t1b_spo2", 32'(spo2_cfg), 32'h47);

        // PART_ID read with NACK
        i2c_start();
        send_byte(8'hAE, ack);
        send_byte(8'hFF, ack);
        i2c_start();
        send_byte(8'hAF, ack);
        check("t2_addr_ack", 32'(ack), 1);
        recv_byte(1'b0, rb);
        check("t2_part_id", 32'(rb), 32'h11);
        check("t2_sda_rel", 32'(sda), 1);
        check("t2_busy_nack", 32'(busy), 0);
        i2c_stop();

        // Two samples, register views, then a 4-byte FIFO_DATA read
        push(16'hA1B2);
        push(16'hC3D4);
        check("t3_count2", 32'(buf_count), 2);
        read_reg(8'h02, rb);
        check("t3_wr_ptr", 32'(rb), 32'h02);
        read_reg(8'h00, rb);
        check("t3_int_status", 32'(rb), 32'h20);
        i2c_start();
        send_byte(8'hAE, ack);
        send_byte(8'h09, ack);
        i2c_start();
        send_byte(8'hAF, ack);
        recv_byte(1'b1, rb);
        check("t3_b0", 32'(rb), 32'hA1);
        recv_byte(1'b1, rb);
        check("t3_b1", 32'(rb), 32'hB2);
        check("t3_count1", 32'(buf_count), 1);
        recv_byte(1'b1, rb);
        check("t3_b2", 32'(rb), 32'hC3);
        recv_byte(1'b0, rb);
        check("t3_b3", 32'(rb), 32'hD4);
        i2c_stop();
        check("t3_count0", 32'(buf_count), 0);

        // Wrong address: no ACK, rest of transfer ignored
        i2c_start();
        send_byte(8'h78, ack);
        check("t4_addr_nack", 32'(ack), 0);
        check("t4_busy", 32'(busy), 0);
        send_byte(8'h06, ack);
        check("t4_reg_nack", 32'(ack), 0);
        send_byte(8'hFF, ack);
        i2c_stop();
        check("t4_mode", 32'(mode_cfg), 32'h05);
        check("t4_spo2", 32'(spo2_cfg), 32'h47);
        check("t4_busy_end", 32'(busy), 0);

        // Fill, overflow by one, clear-on-read of OVF_COUNTER
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
        check("t5_ready_full", 32'(sample_ready), 0);
        check("t5_count_full", 32'(buf_count), 8);
        push(16'hDEAD);
        check("t5_count_drop", 32'(buf_count), 8);
        read_reg(8'h04, rb);
        check("t5_ovf1", 32'(rb), 32'h01);
        read_reg(8'h04, rb);
        check("t5_ovf0", 32'(rb), 32'h00);

        // Drain all 8 words; the dropped word must not appear
        i2c_start();
        send_byte(8'hAE, ack);
        send_byte(8'h09, ack);
        i2c_start();
        send_byte(8'hAF, ack);
        for (int k = 0; k < 16; k++) begin
            recv_byte((k != 15), rb);
            check("t5_drain", 32'(rb), (k % 2 == 0) ? 32'h10 : 32'(k / 2));
        end
        i2c_stop();
        check("t5_count_empty", 32'(buf_count), 0);
        check("t5_ready_empty", 32'(sample_ready), 1);

        // Empty FIFO_DATA read
        i2c_start();
        send_byte(8'hAE, ack);
        send_byte(8'h09, ack);
        i2c_start();
        send_byte(8'hAF, ack);
        recv_byte(1'b1, rb);
        check("t6_empty_msb", 32'(rb), 0);
        recv_byte(1'b0, rb);
        check("t6_empty_lsb", 32'(rb), 0);
        i2c_stop();
        check("t6_count", 32'(buf_count), 0);

        // Reset while the target drives the PART_ID MSB (a 0)
        push(16'h1234);
        i2c_start();
        send_byte(8'hAE, ack);
        send_byte(8'hFF, ack);
        i2c_start();
        send_byte(8'hAF, ack);
        check("t6_drive_low", 32'(sda), 0);
        check("t6_busy_rd", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sda", 32'(sda), 1);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_mode", 32'(mode_cfg), 0);
        check("t6_rst_spo2", 32'(spo2_cfg), 0);
        check("t6_rst_ready", 32'(sample_ready), 1);
        check("t6_rst_count", 32'(buf_count), 0);
        clks(2);
        rst_n = 1'b1;
        clks(2);
        i2c_stop();

        // Target is back in service after reset
        i2c_start();
        send_byte(8'hAE, ack);
        check("t6_post_ack", 32'(ack), 1);
        send_byte(8'h06, ack);
        send_byte(8'h09, ack);
        i2c_stop();
        check("t6_post_mode", 32'(mode_cfg), 32'h09);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
